// File: rtl/missile_trajectory_ctrl.sv
// Single-missile launcher, flight controller and pixel drawer for the playfield.
// Optional build macro MISSILE_AUTOFIRE_EN: fire on key level instead of rising edge.
module missile_trajectory_ctrl #(
   parameter int         MISSILE_W       = 4,
   parameter int         MISSILE_H       = 12,
   parameter int         SPEED           = 8,
   parameter int         COOLDOWN_FRAMES = 8,
   parameter logic [7:0] MISSILE_COLOR   = 8'h1F
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        startOfFrame,
   input  logic        fireKey,
   input  logic        collision,
   input  logic        InsideRectangle,
   input  logic [10:0] offsetX,
   input  logic [10:0] offsetY,
   input  logic [10:0] offsetXPlayerCenter,
   input  logic [10:0] offsetYPlayerCenter,
   output logic        drawingRequest,
   output logic [7:0]  RGBout,
   output logic        missileActive,
   output logic [10:0] missileX,
   output logic [10:0] missileY
);

   typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_t;

   localparam logic [10:0] HALF_W  = 11'(MISSILE_W / 2);
   localparam logic [10:0] H_11    = 11'(MISSILE_H);
   localparam logic [10:0] SPEED_11 = 11'(SPEED);
   localparam logic [11:0] W_12    = 12'(MISSILE_W);
   localparam logic [11:0] H_12    = 12'(MISSILE_H);
   localparam logic [7:0]  CD_LOAD = 8'(COOLDOWN_FRAMES);

   state_t      state, state_next;
   logic [10:0] x_next, y_next;
   logic [7:0]  cnt, cnt_next;
   logic        fire_hist, fire_evt, fire_now;
   logic [10:0] launch_x, launch_y;
   logic [11:0] ox, oy, mx, my;
   logic        draw_next;
   logic [7:0]  rgb_next;

`ifdef MISSILE_AUTOFIRE_EN
   assign fire_now = fireKey;
`else
   assign fire_now = fireKey & ~fire_hist;
`endif

   // Launch point: centred above the player, clamped to the playfield origin.
   assign launch_x = (offsetXPlayerCenter >= HALF_W) ? offsetXPlayerCenter - HALF_W : 11'd0;
   assign launch_y = (offsetYPlayerCenter >= H_11)   ? offsetYPlayerCenter - H_11   : 11'd0;

   assign missileActive = (state == FLYING);

   always_comb begin
      state_next = state;
      x_next     = missileX;
      y_next     = missileY;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (fire_evt) begin
               x_next     = launch_x;
               y_next     = launch_y;
               state_next = FLYING;
            end
         end
         FLYING: begin
            if (collision) begin
               state_next = COOLDOWN;
               cnt_next   = CD_LOAD;
            end else if (startOfFrame) begin
               if (missileY < SPEED_11) begin
                  state_next = COOLDOWN;
                  cnt_next   = CD_LOAD;
               end else begin
                  y_next = missileY - SPEED_11;
               end
            end
         end
         COOLDOWN: begin
            if (startOfFrame) begin
               if (cnt <= 8'd1) begin
                  state_next = IDLE;
                  cnt_next   = 8'd0;
               end else begin
                  cnt_next = cnt - 8'd1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // 12-bit compares keep the +W/+H upper bounds from wrapping.
   assign ox = {1'b0, offsetX};
   assign oy = {1'b0, offsetY};
   assign mx = {1'b0, missileX};
   assign my = {1'b0, missileY};

   assign draw_next = (state == FLYING) && InsideRectangle &&
                      (ox >= mx) && (ox < mx + W_12) &&
                      (oy >= my) && (oy < my + H_12);
   assign rgb_next  = draw_next ? MISSILE_COLOR : 8'hFF;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state          <= IDLE;
         missileX       <= 11'd0;
         missileY       <= 11'd0;
         cnt            <= 8'd0;
         fire_hist      <= 1'b0;
         fire_evt       <= 1'b0;
         drawingRequest <= 1'b0;
         RGBout         <= 8'hFF;
      end else begin
         state          <= state_next;
         missileX       <= x_next;
         missileY       <= y_next;
         cnt            <= cnt_next;
         fire_hist      <= fireKey;
         fire_evt       <= fire_now;
         drawingRequest <= draw_next;
         RGBout         <= rgb_next;
      end
   end

endmodule

// File: tb/tb_missile_trajectory_ctrl.sv
// Directed bench for missile_trajectory_ctrl with a scoreboard of expected outputs.
module tb_missile_trajectory_ctrl;

   logic        clk = 1'b0;
   logic        resetN;
   logic        startOfFrame, fireKey, collision, InsideRectangle;
   logic [10:0] offsetX, offsetY, offsetXPlayerCenter, offsetYPlayerCenter;
   logic        drawingRequest, missileActive;
   logic [7:0]  RGBout;
   logic [10:0] missileX, missileY;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int          kind;
      logic [31:0] val;
      string       tag;
   } exp_t;
   exp_t exp_q[$];

   missile_trajectory_ctrl dut (
      .clk                 (clk),
      .resetN              (resetN),
      .startOfFrame        (startOfFrame),
      .fireKey             (fireKey),
      .collision           (collision),
      .InsideRectangle     (InsideRectangle),
      .offsetX             (offsetX),
      .offsetY             (offsetY),
      .offsetXPlayerCenter (offsetXPlayerCenter),
      .offsetYPlayerCenter (offsetYPlayerCenter),
      .drawingRequest      (drawingRequest),
      .RGBout              (RGBout),
      .missileActive       (missileActive),
      .missileX            (missileX),
      .missileY            (missileY)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] observe(int kind);
      case (kind)
         0:       return {31'd0, missileActive};
         1:       return {21'd0, missileX};
         2:       return {21'd0, missileY};
         3:       return {31'd0, drawingRequest};
         default: return {24'd0, RGBout};
      endcase
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic push(int kind, logic [31:0] val, string tag);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      e.tag  = tag;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.tag, observe(e.kind), e.val);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic frame();
      startOfFrame = 1'b1;
      tick();
      startOfFrame = 1'b0;
   endtask

   task automatic frames(int n);
      for (int i = 0; i < n; i++) frame();
   endtask

   // Raise fireKey and expect flight two edges later at the given launch point.
   task automatic launch(logic [10:0] ex, logic [10:0] ey, string tag);
      fireKey = 1'b1;
      push(0, 0, {tag, "_active_lat1"});
      tick();
      drain();
      push(0, 1, {tag, "_active"});
      push(1, ex, {tag, "_x"});
      push(2, ey, {tag, "_y"});
      tick();
      drain();
   endtask

   task automatic draw_probe(logic ins, logic [10:0] px, logic [10:0] py, logic expd, string tag);
      InsideRectangle = ins;
      offsetX = px;
      offsetY = py;
      push(3, expd, {tag, "_draw"});
      push(4, expd ? 32'h1F : 32'hFF, {tag, "_rgb"});
      tick();
      drain();
   endtask

   initial begin
      resetN = 1'b0;
      startOfFrame = 1'b0; fireKey = 1'b0; collision = 1'b0; InsideRectangle = 1'b0;
      offsetX = '0; offsetY = '0; offsetXPlayerCenter = '0; offsetYPlayerCenter = '0;

      #12;
      push(0, 0, "rst_active"); push(1, 0, "rst_x"); push(2, 0, "rst_y");
      push(3, 0, "rst_draw");   push(4, 32'hFF, "rst_rgb");
      drain();
      resetN = 1'b1;
      tick();

      // Launch from (100,400) and fly to the top edge.
      offsetXPlayerCenter = 11'd100;
      offsetYPlayerCenter = 11'd400;
      launch(11'd98, 11'd388, "launch1");
      fireKey = 1'b0;
      for (int k = 1; k <= 48; k++) begin
         push(2, 388 - 8 * k, $sformatf("fly_y_%0d", k));
         push(0, 1, $sformatf("fly_active_%0d", k));
         frame();
         drain();
      end
      push(0, 0, "top_retire_active");
      push(2, 4, "top_retire_y");
      frame();
      drain();

      // Seven cooldown frames: a fire press must still be ignored.
      frames(7);
      fireKey = 1'b1;
      tick(); tick();
      push(0, 0, "cooldown7_fire_ignored");
      drain();
      fireKey = 1'b0;
      tick();
      frame();
      launch(11'd98, 11'd388, "launch2");
      fireKey = 1'b0;

      frames(11);
      push(2, 300, "fly_to_300");
      drain();

      draw_probe(1'b1, 11'd98,  11'd300, 1'b1, "draw_origin");
      draw_probe(1'b1, 11'd102, 11'd300, 1'b0, "draw_right_edge");
      draw_probe(1'b1, 11'd98,  11'd312, 1'b0, "draw_bottom_edge");
      draw_probe(1'b1, 11'd101, 11'd311, 1'b1, "draw_far_corner");
      draw_probe(1'b1, 11'd97,  11'd305, 1'b0, "draw_left_out");
      draw_probe(1'b0, 11'd98,  11'd300, 1'b0, "draw_outside_rect");
      InsideRectangle = 1'b0;

      // Collision coincident with a frame pulse: no move, retire.
      collision = 1'b1;
      startOfFrame = 1'b1;
      push(0, 0, "coll_active");
      push(2, 300, "coll_y_hold");
      tick();
      drain();
      collision = 1'b0;
      startOfFrame = 1'b0;
      fireKey = 1'b1;
      tick(); tick();
      push(0, 0, "coll_cooldown_fire_ignored");
      drain();
      fireKey = 1'b0;
      frames(8);
      tick();
      push(0, 0, "coll_idle_no_launch");
      push(2, 300, "coll_idle_y_hold");
      drain();

      // Saturation at the playfield origin.
      offsetXPlayerCenter = 11'd1;
      offsetYPlayerCenter = 11'd5;
      launch(11'd0, 11'd0, "sat");
      fireKey = 1'b0;
      push(0, 0, "sat_first_frame_retire");
      frame();
      drain();
      frames(8);

      // Asynchronous abort mid-flight.
      offsetXPlayerCenter = 11'd100;
      offsetYPlayerCenter = 11'd400;
      launch(11'd98, 11'd388, "launch_rst");
      fireKey = 1'b0;
      #2;
      resetN = 1'b0;
      #1;
      push(0, 0, "async_rst_active");
      push(1, 0, "async_rst_x");
      push(2, 0, "async_rst_y");
      drain();
      resetN = 1'b1;
      tick();

      // Fire held across flight and full cooldown.
      launch(11'd98, 11'd388, "held");
      collision = 1'b1;
      push(0, 0, "held_coll_active");
      tick();
      drain();
      collision = 1'b0;
      frames(8);
      tick();
`ifdef MISSILE_AUTOFIRE_EN
      push(0, 1, "held_autofire_relaunch");
      push(2, 388, "held_autofire_y");
`else
      push(0, 0, "held_single_launch_a");
      drain();
      tick(); tick();
      push(0, 0, "held_single_launch_b");
`endif
      drain();
      fireKey = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
